decode_issue: RTL and testbench

- RV32I decode/issue stage. It sits between fetch and execute, directly upstream of reg_file.
- It decodes the instruction and drives the reg_file read addresses. It captures the operands, generates the immediate, and holds the decoded bundle in an ID/EX output register.
- A 32-entry busy scoreboard stalls issue on RAW and WAW hazards against in-flight writers. The writeback port clears scoreboard entries and provides a same-cycle bypass.

---
 rtl/rv32_pkg.sv | 46 ++++
 rtl/imm_gen.sv | 35 +++
 rtl/decode_issue.sv | 199 +++++++++++++++++++
 tb/tb_decode_issue.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// ============================================================================
// Module   : rv32_pkg
// Brief    : RV32I opcode constants and immediate-format helpers for decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opc);
        imm_fmt_e fmt;
        case (opc)
            OPC_OPIMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
            OPC_STORE:                     fmt = IMM_S;
            OPC_BRANCH:                    fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:            fmt = IMM_U;
            OPC_JAL:                       fmt = IMM_J;
            default:                       fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen.sv
// ============================================================================
// Module   : imm_gen
// Brief    : Combinational RV32I immediate generator (format chosen by opcode).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm
);

    imm_fmt_e w_fmt;

    assign w_fmt = imm_fmt_of(i_instr[6:0]);

    always_comb begin
        o_imm = '0;
        case (w_fmt)
            IMM_I: o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
            IMM_S: o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: o_imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U: o_imm = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'b0};
            IMM_J: o_imm = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/decode_issue.sv
// ============================================================================
// Module   : decode_issue
// Brief    : RV32I decode/issue stage with busy scoreboard, WB bypass and ID/EX register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_issue #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [31:0]     if_pc,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_pc,
    output logic [XLEN-1:0] id_rs1_val,
    output logic [XLEN-1:0] id_rs2_val,
    output logic [XLEN-1:0] id_imm,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_funct3,
    output logic [6:0]      id_funct7,
    output logic [4:0]      id_rd,
    output logic            id_wen,
    output logic            id_illegal
);

    import rv32_pkg::*;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_writes;
    logic            w_wen;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;
    logic            w_clr1;
    logic            w_clr2;
    logic            w_clr_rd;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic            w_hazard;
    logic            w_issue;
    logic [NREG-1:0] w_busy_nxt;

    logic [NREG-1:0] r_busy;
    logic            r_id_valid;
    logic [31:0]     r_id_pc;
    logic [XLEN-1:0] r_id_rs1_val;
    logic [XLEN-1:0] r_id_rs2_val;
    logic [XLEN-1:0] r_id_imm;
    logic [6:0]      r_id_opcode;
    logic [2:0]      r_id_funct3;
    logic [6:0]      r_id_funct7;
    logic [4:0]      r_id_rd;
    logic            r_id_wen;
    logic            r_id_illegal;

    assign w_opcode  = if_instr[6:0];
    assign w_rd      = if_instr[11:7];
    assign w_rs1     = if_instr[19:15];
    assign w_rs2     = if_instr[24:20];
    assign rf_raddr1 = w_rs1;
    assign rf_raddr2 = w_rs2;

    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_writes  = 1'b0;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                w_writes = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                w_use_rs1 = 1'b1;
                w_writes  = 1'b1;
            end
            OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_writes  = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_wen = w_writes && (w_rd != 5'd0);

    imm_gen u_imm_gen (
        .i_instr (if_instr),
        .o_imm   (w_imm)
    );

    // A writeback landing this cycle both forwards its data and retires the busy bit.
    assign w_clr1   = wb_en && (wb_addr == w_rs1) && (w_rs1 != 5'd0);
    assign w_clr2   = wb_en && (wb_addr == w_rs2) && (w_rs2 != 5'd0);
    assign w_clr_rd = wb_en && (wb_addr == w_rd);
    assign w_op1    = w_clr1 ? wb_data : rf_rdata1;
    assign w_op2    = w_clr2 ? wb_data : rf_rdata2;

    assign w_hazard = (w_use_rs1 && (w_rs1 != 5'd0) && r_busy[w_rs1] && !w_clr1)
                   || (w_use_rs2 && (w_rs2 != 5'd0) && r_busy[w_rs2] && !w_clr2)
                   || (w_wen && r_busy[w_rd] && !w_clr_rd);

    assign if_ready = !w_hazard && !flush && (!r_id_valid || id_ready);
    assign w_issue  = if_valid && if_ready;

    // Clears are applied first so that a same-index set on issue takes priority.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_en && (wb_addr != 5'd0)) begin
            w_busy_nxt[wb_addr] = 1'b0;
        end
        if (flush && r_id_valid && r_id_wen) begin
            w_busy_nxt[r_id_rd] = 1'b0;
        end
        if (w_issue && w_wen) begin
            w_busy_nxt[w_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_valid   <= 1'b0;
            r_id_pc      <= '0;
            r_id_rs1_val <= '0;
            r_id_rs2_val <= '0;
            r_id_imm     <= '0;
            r_id_opcode  <= '0;
            r_id_funct3  <= '0;
            r_id_funct7  <= '0;
            r_id_rd      <= '0;
            r_id_wen     <= 1'b0;
            r_id_illegal <= 1'b0;
        end else if (flush) begin
            r_id_valid <= 1'b0;
        end else if (w_issue) begin
            r_id_valid   <= 1'b1;
            r_id_pc      <= if_pc;
            r_id_rs1_val <= w_op1;
            r_id_rs2_val <= w_op2;
            r_id_imm     <= w_imm;
            r_id_opcode  <= w_opcode;
            r_id_funct3  <= if_instr[14:12];
            r_id_funct7  <= if_instr[31:25];
            r_id_rd      <= w_rd;
            r_id_wen     <= w_wen;
            r_id_illegal <= w_illegal;
        end else if (r_id_valid && id_ready) begin
            r_id_valid <= 1'b0;
        end
    end

    assign id_valid   = r_id_valid;
    assign id_pc      = r_id_pc;
    assign id_rs1_val = r_id_rs1_val;
    assign id_rs2_val = r_id_rs2_val;
    assign id_imm     = r_id_imm;
    assign id_opcode  = r_id_opcode;
    assign id_funct3  = r_id_funct3;
    assign id_funct7  = r_id_funct7;
    assign id_rd      = r_id_rd;
    assign id_wen     = r_id_wen;
    assign id_illegal = r_id_illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_issue.sv
// ============================================================================
// Module   : tb_decode_issue
// Brief    : Self-checking bench for decode_issue (vector table + scoreboard queue).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_val;
    logic [31:0] id_rs2_val;
    logic [31:0] id_imm;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic [4:0]  id_rd;
    logic        id_wen;
    logic        id_illegal;

    decode_issue dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_pc      (id_pc),
        .id_rs1_val (id_rs1_val),
        .id_rs2_val (id_rs2_val),
        .id_imm     (id_imm),
        .id_opcode  (id_opcode),
        .id_funct3  (id_funct3),
        .id_funct7  (id_funct7),
        .id_rd      (id_rd),
        .id_wen     (id_wen),
        .id_illegal (id_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } bundle_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic        wen;
        logic        ill;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    bundle_t     exp_q[$];
    vec_t        vecs[12];
    logic [31:0] rf[32];
    logic [31:0] cur_imm;
    logic        cur_wen;
    logic        cur_ill;

    // Reference register file: combinational read, written by the writeback port.
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always @(posedge clk) begin
        if (wb_en && wb_addr != 5'd0) rf[wb_addr] <= wb_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: push on issue, drop on flush, compare on every transfer into execute.
    always @(negedge clk) begin
        bundle_t e;
        bundle_t a;
        if (!rst) begin
            if (flush && id_valid) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (id_valid && id_ready) begin
                n_checks++;
                a.pc = id_pc; a.rs1 = id_rs1_val; a.rs2 = id_rs2_val; a.imm = id_imm;
                a.opcode = id_opcode; a.funct3 = id_funct3; a.funct7 = id_funct7;
                a.rd = id_rd; a.wen = id_wen; a.ill = id_illegal;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bundle: got unexpected bundle pc=%h, expected none", id_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        n_fail++;
                        $display("FAIL bundle pc=%h: got %h, expected %h", e.pc, a, e);
                    end
                end
            end
            if (if_valid && if_ready) begin
                e.pc     = if_pc;
                e.rs1    = (wb_en && wb_addr == if_instr[19:15] && if_instr[19:15] != 5'd0)
                           ? wb_data : rf[if_instr[19:15]];
                e.rs2    = (wb_en && wb_addr == if_instr[24:20] && if_instr[24:20] != 5'd0)
                           ? wb_data : rf[if_instr[24:20]];
                e.imm    = cur_imm;
                e.opcode = if_instr[6:0];
                e.funct3 = if_instr[14:12];
                e.funct7 = if_instr[31:25];
                e.rd     = if_instr[11:7];
                e.wen    = cur_wen;
                e.ill    = cur_ill;
                exp_q.push_back(e);
            end
        end
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] imm, input logic wen, input logic ill);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        cur_imm  = imm;
        cur_wen  = wen;
        cur_ill  = ill;
    endtask

    task automatic issue_one(input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] imm, input logic wen, input logic ill);
        bit ok = 1'b0;
        drive(instr, pc, imm, wen, ill);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout pc=%h: got no issue, expected issue within 20 cycles", pc);
        end
        @(posedge clk); #1;
        if_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst      = 1'b1;
        if_valid = 1'b0;
        wb_en    = 1'b0;
        flush    = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; id_ready = 1'b1;
        cur_imm = '0; cur_wen = 1'b0; cur_ill = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + i;

        vecs[0]  = '{{12'd5, 5'd0, 3'b000, 5'd1, 7'h13},            32'h0000_0005, 1'b1, 1'b0};
        vecs[1]  = '{32'hABCD_E2B7,                                 32'hABCD_E000, 1'b1, 1'b0};
        vecs[2]  = '{32'hFE00_0EE3,                                 32'hFFFF_FFFC, 1'b0, 1'b0};
        vecs[3]  = '{{7'h7F, 5'd7, 5'd6, 3'b010, 5'h1F, 7'h23},     32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[4]  = '{{1'b0, 10'd0, 1'b1, 8'd0, 5'd8, 7'h6F},        32'h0000_0800, 1'b1, 1'b0};
        vecs[5]  = '{{20'h80000, 5'd9, 7'h17},                      32'h8000_0000, 1'b1, 1'b0};
        vecs[6]  = '{{7'h00, 5'd7, 5'd6, 3'b000, 5'd10, 7'h33},     32'h0000_0000, 1'b1, 1'b0};
        vecs[7]  = '{{7'h20, 5'd7, 5'd6, 3'b000, 5'd11, 7'h33},     32'h0000_0000, 1'b1, 1'b0};
        vecs[8]  = '{{12'hFF8, 5'd6, 3'b010, 5'd12, 7'h03},         32'hFFFF_FFF8, 1'b1, 1'b0};
        vecs[9]  = '{{12'd4, 5'd7, 3'b000, 5'd13, 7'h67},           32'h0000_0004, 1'b1, 1'b0};
        vecs[10] = '{{12'd1, 5'd0, 3'b000, 5'd0, 7'h13},            32'h0000_0001, 1'b0, 1'b0};
        vecs[11] = '{{7'h00, 5'd1, 5'd1, 3'b000, 5'd1, 7'h7F},      32'h0000_0000, 1'b0, 1'b1};

        // Reset state, with ADDI x1,x0,5 already presented.
        #1 rst = 1'b1;
        drive({12'd5, 5'd0, 3'b000, 5'd1, 7'h13}, 32'h0000_0000, 32'h5, 1'b1, 1'b0);
        @(negedge clk);
        check("rst_id_valid", {31'b0, id_valid}, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_imm", id_imm, 32'h0);
        check("rst_id_fields", {id_opcode, id_funct3, id_funct7, id_rd, id_wen, id_illegal}, 32'h0);
        check("rst_busy", dut.r_busy, 32'h0);
        check("rst_if_ready", {31'b0, if_ready}, 32'h1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("if_ready_after_rst", {31'b0, if_ready}, 32'h1);
        @(posedge clk); #1 if_valid = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Table of decode/immediate vectors with independent destinations.
        for (int i = 0; i < 12; i++)
            issue_one(vecs[i].instr, 32'h100 + 32'(i * 4), vecs[i].imm, vecs[i].wen, vecs[i].ill);
        @(posedge clk); #1;
        check("busy_after_table", dut.r_busy, 32'h0000_3F22);

        // Reset mid-cycle while a bundle is held and busy bits are set.
        id_ready = 1'b0;
        issue_one({12'd3, 5'd0, 3'b000, 5'd14, 7'h13}, 32'h180, 32'h3, 1'b1, 1'b0);
        @(negedge clk); #2 rst = 1'b1; #1;
        check("midrst_id_valid", {31'b0, id_valid}, 32'h0);
        check("midrst_busy", dut.r_busy, 32'h0);
        check("midrst_id_pc", id_pc, 32'h0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0; id_ready = 1'b1;

        // RAW stall resolved by same-cycle writeback bypass.
        issue_one({12'd5, 5'd0, 3'b000, 5'd1, 7'h13}, 32'h200, 32'h5, 1'b1, 1'b0);
        drive({7'h00, 5'd1, 5'd1, 3'b000, 5'd2, 7'h33}, 32'h204, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("raw_stall_1", {31'b0, if_ready}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("raw_stall_2", {31'b0, if_ready}, 32'h0);
        @(posedge clk); #1;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h5;
        @(negedge clk);
        check("raw_bypass_ready", {31'b0, if_ready}, 32'h1);
        @(posedge clk); #1;
        wb_en = 1'b0; if_valid = 1'b0;
        check("raw_busy1", {31'b0, dut.r_busy[1]}, 32'h0);
        check("raw_busy2", {31'b0, dut.r_busy[2]}, 32'h1);
        repeat (2) @(posedge clk);

        // Backpressure: held bundle stays stable, issue resumes on release.
        do_reset();
        id_ready = 1'b0;
        issue_one({12'd7, 5'd0, 3'b000, 5'd20, 7'h13}, 32'h300, 32'h7, 1'b1, 1'b0);
        drive({12'd8, 5'd0, 3'b000, 5'd21, 7'h13}, 32'h304, 32'h8, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_if_ready", {31'b0, if_ready}, 32'h0);
            check("bp_id_valid", {31'b0, id_valid}, 32'h1);
            check("bp_id_pc", id_pc, 32'h300);
            check("bp_id_imm_rd", {id_imm[26:0], id_rd}, {27'd7, 5'd20});
            @(posedge clk); #1;
        end
        id_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'b0, if_ready}, 32'h1);
        @(posedge clk); #1 if_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Flush kills the held writer and releases its busy bit.
        do_reset();
        id_ready = 1'b0;
        issue_one({12'd9, 5'd0, 3'b000, 5'd3, 7'h13}, 32'h400, 32'h9, 1'b1, 1'b0);
        drive({7'h00, 5'd0, 5'd3, 3'b000, 5'd4, 7'h33}, 32'h404, 32'h0, 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_if_ready", {31'b0, if_ready}, 32'h0);
        @(posedge clk); #1 flush = 1'b0;
        check("flush_id_valid", {31'b0, id_valid}, 32'h0);
        check("flush_busy3", {31'b0, dut.r_busy[3]}, 32'h0);
        @(negedge clk);
        check("flush_next_ready", {31'b0, if_ready}, 32'h1);
        @(posedge clk); #1;
        if_valid = 1'b0; id_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("queue_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
